spm_ex_loader: RTL
==================

# spm_ex_loader

External-port transfer engine for the four-bank-group scratchpad. It accepts one block-transfer command at a time: a target bank group, a base address, a word count and a direction. It then sequences `ex_bus` word by word, writing streamed host data or issuing reads. While a command is active it overrides the scratchpad instruction word so that the target bank group is enabled and takes its din/addr/wen/ren from the external path. It sits between the host/DMA side and the scratchpad's `inst` and `ex_bus` inputs.

## Interface
Parameters:
- `A_W`, 10: scratchpad word-address width.
- `D_W`, 32: data width.
- `LEN_W`, 11: word-count width (max 1024 words).

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both valid and ready are high.
- `cmd_write` in 1: 1 = write to SPM, 0 = read.
- `cmd_bg` in 2: target bank group, 0..3.
- `cmd_base` in A_W: first word address.
- `cmd_len` in LEN_W: word count.
- `wr_valid` in 1: write-data handshake, valid.
- `wr_ready` out 1: write-data handshake, ready.
- `wr_data` in D_W: write data.
- `rd_stall` in 1: holds read issue while high.
- `rd_tag_valid` out 1: pulses with each issued read.
- `rd_tag_addr` out A_W: address of the issued read.
- `inst_base` in 20: static SPM instruction from the global configuration.
- `spm_inst` out 20: instruction driven to the scratchpad.
- `ex_bus` out 2+A_W+D_W: {wen, ren, addr, data}.
- `busy` out 1: high in any non-IDLE state.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse for a rejected command (bounds check only).

## Operation
- FSM states: IDLE, SETUP, XFER, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, latch bg, base, len and dir.
  - len=0: go to DONE directly with no bus beat.
  - Otherwise go to SETUP.
- SETUP: one cycle. Applies the instruction override only, so the bank group enable settles before the first access. Go to XFER.
- XFER, write direction:
  - `wr_ready`=1.
  - Each `wr_valid` cycle is one beat.
  - Next cycle `ex_bus` = {1, 0, cur_addr, wr_data}.
- XFER, read direction:
  - Each cycle with `rd_stall`=0 is one beat.
  - Next cycle `ex_bus` = {0, 1, cur_addr, 0}, with `rd_tag_valid`=1 and `rd_tag_addr`=cur_addr.
- Cycles with no beat drive wen=ren=0, and addr/data hold their previous values.
- After each beat: cur_addr increments by 1 and remaining decrements by 1. When remaining reaches 0, go to DONE.
- DONE: one cycle.
  - `done`=1.
  - `ex_bus` carries the final beat (registered).
  - Override is still applied.
  - Go to IDLE.
- Instruction override, for target bg b in SETUP/XFER/DONE:
  - `spm_inst` = `inst_base` with bit 8+b (BGb_en) forced to 1 and bit 4+b (BGb_sel) forced to 0.
  - All other bits pass through.
- In IDLE, `spm_inst` = `inst_base` with no override.
- Commands offered while busy are not accepted: `cmd_ready`=0 and the command waits.

## Timing
- All outputs are registered.
- Reset values:
  - `ex_bus`=0, `spm_inst`=0.
  - `cmd_ready`=0 during the reset cycle, then 1 in IDLE.
  - `wr_ready`=0, `rd_tag_valid`=0, `rd_tag_addr`=0, `busy`=0, `done`=0, `err`=0.
- `spm_inst` lags `inst_base` by one cycle.
- Stall-free N-word transfer, command accepted at cycle t:
  - SETUP at t+1.
  - Beats accepted t+2..t+N+1.
  - Bus beats appear t+3..t+N+2.
  - `done` at t+N+2.
  - `cmd_ready` is back to 1 at t+N+3.
- A len=0 command gives `done` at t+1.
- Address wrap: cur_addr wraps modulo 2^A_W (1023 → 0), unless the bounds check below is compiled in.
- `rst` asserted mid-transfer: next cycle is IDLE with all outputs at their reset values. No partial beat completes after reset, and no `done` is issued.
- `wr_valid` and `rd_stall` are ignored outside XFER.

## Configuration
- `SPM_LDR_BOUNDS_CHK_EN` defined:
  - At acceptance, if base+len > 2^A_W, the command is accepted but rejected.
  - `err`=1 at t+1, no bus beat and no `done`; the FSM stays in IDLE.
- Undefined: no check and no `err` logic (`err` is tied to 0); addresses wrap.

## Test plan
- Write, bg=2, base=0x010, len=4, data A0..A3, wr_valid held high → `ex_bus` wen=1 at addr 0x010..0x013 on consecutive cycles; `spm_inst` bit10=1 and bit6=0 through DONE; `done` one cycle after the 0x013 beat is accepted.
- Read, bg=0, base=0x3FE, len=4, no bounds check → ren beats at 0x3FE, 0x3FF, 0x000, 0x001, with `rd_tag_addr` matching each.
- Read, len=3, `rd_stall` high for 2 cycles mid-stream → exactly 3 ren beats; gap cycles have wen=ren=0; `done` is delayed by 2 cycles.
- Write with `wr_valid` toggling 1,0,1,0,1 and len=3 → exactly 3 wen beats, in order, at consecutive addresses.
- `rst` asserted during XFER after 2 of 5 beats → next cycle `ex_bus`=0, `busy`=0, no `done`; a following len=1 command completes normally.
- With `SPM_LDR_BOUNDS_CHK_EN`: base=0x3FF, len=2 → `err` pulse, no bus activity; base=0x3FE, len=2 → accepted and `done`.

Source files
------------

// File: rtl/spm_ex_loader.sv
// spm_ex_loader: external-port block transfer engine for the scratchpad.
// Optional acceptance bounds check: define SPM_LDR_BOUNDS_CHK_EN.
module spm_ex_loader #(
  parameter int A_W   = 10,
  parameter int D_W   = 32,
  parameter int LEN_W = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [1:0]           cmd_bg,
  input  logic [A_W-1:0]       cmd_base,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [D_W-1:0]       wr_data,
  input  logic                 rd_stall,
  output logic                 rd_tag_valid,
  output logic [A_W-1:0]       rd_tag_addr,
  input  logic [19:0]          inst_base,
  output logic [19:0]          spm_inst,
  output logic [2+A_W+D_W-1:0] ex_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_write;
  logic [1:0]       r_bg;
  logic [A_W-1:0]   r_cur;
  logic [LEN_W-1:0] r_rem;
  logic             r_cmd_ready;
  logic             r_wr_ready;
  logic             r_tag_v;
  logic [A_W-1:0]   r_tag_a;
  logic [19:0]      r_inst;
  logic             r_wen;
  logic             r_ren;
  logic [A_W-1:0]   r_addr;
  logic [D_W-1:0]   r_data;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_beat;
  logic             w_oob;
  logic [19:0]      w_inst_cmd;
  logic [19:0]      w_inst_cur;

  // Force BGb_en (bit 8+b) high and BGb_sel (bit 4+b) low.
  function automatic logic [19:0] f_ovr(
    input logic [19:0] b,
    input logic [1:0]  bg
  );
    logic [19:0] v;
    logic [3:0]  m;
    m       = 4'b0001 << bg;
    v       = b;
    v[11:8] = b[11:8] | m;
    v[7:4]  = b[7:4] & ~m;
    return v;
  endfunction

  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_beat     = r_write ? wr_valid : !rd_stall;
  assign w_inst_cmd = f_ovr(inst_base, cmd_bg);
  assign w_inst_cur = f_ovr(inst_base, r_bg);

`ifdef SPM_LDR_BOUNDS_CHK_EN
  localparam int SUM_W = ((A_W > LEN_W) ? A_W : LEN_W) + 1;
  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(1) << A_W;

  logic [SUM_W-1:0] w_end;
  logic             r_err;

  assign w_end = SUM_W'(cmd_base) + SUM_W'(cmd_len);
  assign w_oob = w_end > LIMIT;
  assign err   = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && w_accept && w_oob;
    end
  end
`else
  assign w_oob = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_bg        <= '0;
      r_cur       <= '0;
      r_rem       <= '0;
      r_cmd_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_tag_v     <= 1'b0;
      r_tag_a     <= '0;
      r_inst      <= '0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wen   <= 1'b0;
      r_ren   <= 1'b0;
      r_tag_v <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          r_inst      <= inst_base;
          if (w_accept && !w_oob) begin
            r_write     <= cmd_write;
            r_bg        <= cmd_bg;
            r_cur       <= cmd_base;
            r_rem       <= cmd_len;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_inst      <= w_inst_cmd;
            if (cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          r_state    <= S_XFER;
          r_wr_ready <= r_write;
          r_inst     <= w_inst_cur;
        end
        S_XFER: begin
          r_inst <= w_inst_cur;
          if (w_beat) begin
            r_wen   <= r_write;
            r_ren   <= !r_write;
            r_addr  <= r_cur;
            r_data  <= r_write ? wr_data : '0;
            r_tag_v <= !r_write;
            if (!r_write) begin
              r_tag_a <= r_cur;
            end
            r_cur <= r_cur + 1'b1;
            r_rem <= r_rem - 1'b1;
            if (r_rem == LEN_W'(1)) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_wr_ready <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_inst      <= inst_base;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign wr_ready     = r_wr_ready;
  assign rd_tag_valid = r_tag_v;
  assign rd_tag_addr  = r_tag_a;
  assign spm_inst     = r_inst;
  assign ex_bus       = {r_wen, r_ren, r_addr, r_data};
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
